// File: rtl/bnn_act_packer.sv
// ============================================================================
//  Module   : bnn_act_packer
//  Purpose  : Packs serial binarized PU activations into WORD_W-bit words and
//             queues them in a small FIFO behind a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_act_packer #(
    parameter int WORD_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         act_bit,
    input  logic                         act_en,
    input  logic                         flush,
    output logic [WORD_W-1:0]            o_data,
    output logic [$clog2(WORD_W+1)-1:0]  o_nbits,
    output logic                         o_val,
    input  logic                         o_rdy,
    output logic                         overflow
);

    localparam int c_CNT_W = $clog2(WORD_W);
    localparam int c_NB_W  = $clog2(WORD_W + 1);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [WORD_W-1:0]  r_acc;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WORD_W-1:0]  r_mem_data  [FIFO_DEPTH];
    logic [c_NB_W-1:0]  r_mem_nbits [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_OCC_W-1:0] r_occ;
    logic               r_overflow;

    logic [WORD_W-1:0]  w_acc_next;
    logic [c_NB_W-1:0]  w_nbits;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_wr;

    // Accumulator including this cycle's bit, so a completing or flushing
    // word can be written straight into the FIFO.
    always_comb begin
        w_acc_next = r_acc;
        if (act_en) begin
            w_acc_next[r_cnt] = act_bit;
        end
    end

    assign w_last  = act_en && (r_cnt == c_CNT_W'(WORD_W - 1));
    assign w_push  = w_last || (flush && ((r_cnt != '0) || act_en));
    assign w_nbits = c_NB_W'(r_cnt) + c_NB_W'(act_en);
    assign w_pop   = o_val && o_rdy;
    assign w_full  = (r_occ == c_OCC_W'(FIFO_DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (act_en) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i]  <= '0;
                r_mem_nbits[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem_data[r_wptr]  <= w_acc_next;
            r_mem_nbits[r_wptr] <= w_nbits;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            if (w_wr && !w_pop) begin
                r_occ <= r_occ + c_OCC_W'(1);
            end else if (!w_wr && w_pop) begin
                r_occ <= r_occ - c_OCC_W'(1);
            end
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_val    = (r_occ != '0);
    assign o_data   = r_mem_data[r_rptr];
    assign o_nbits  = r_mem_nbits[r_rptr];
    assign overflow = r_overflow;

endmodule

`default_nettype wire
